// File: rtl/decoder_sel_sequencer.sv
// Channel-scan sequencer producing the 3-bit select code for decoder_3to8.
// Optional freeze input enabled by defining DECODER_SEQ_PAUSE_EN.
module decoder_sel_sequencer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
`ifdef DECODER_SEQ_PAUSE_EN
  input  logic               pause,
`endif
  input  logic               continuous,
  input  logic [7:0]         ch_mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [2:0]         sel,
  output logic               sel_valid,
  output logic               busy,
  output logic               sweep_done,
  output logic               err_no_ch
);

  typedef enum logic {IDLE = 1'b0, DWELL = 1'b1} state_t;

  localparam logic [7:0] ABOVE_BASE = 8'hFE;

  state_t             state_q;
  logic [2:0]         sel_q;
  logic               sel_valid_q, busy_q, sweep_done_q, err_q;
  logic [DWELL_W-1:0] cnt_q, dwell_q;
  logic [7:0]         mask_q;
  logic               cont_q;

  logic               hold;
  logic [7:0]         above;
  logic [2:0]         next_sel, first_sel, start_sel;

  function automatic logic [2:0] lowest_idx(input logic [7:0] m);
    lowest_idx = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (m[i]) lowest_idx = i[2:0];
  endfunction

`ifdef DECODER_SEQ_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  // Priority search over channels strictly above the current one.
  assign above     = mask_q & (ABOVE_BASE << sel_q);
  assign next_sel  = lowest_idx(above);
  assign first_sel = lowest_idx(mask_q);
  assign start_sel = lowest_idx(ch_mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sel_q        <= 3'd0;
      sel_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      sweep_done_q <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      dwell_q      <= '0;
      mask_q       <= 8'd0;
      cont_q       <= 1'b0;
    end else begin
      sweep_done_q <= 1'b0;
      err_q        <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !stop) begin
            if (ch_mask != 8'd0) begin
              mask_q      <= ch_mask;
              dwell_q     <= dwell;
              cont_q      <= continuous;
              sel_q       <= start_sel;
              cnt_q       <= dwell;
              sel_valid_q <= 1'b1;
              busy_q      <= 1'b1;
              state_q     <= DWELL;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        DWELL: begin
          if (stop) begin
            sel_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end else if (hold) begin
            cnt_q <= cnt_q;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (above != 8'd0) begin
            sel_q <= next_sel;
            cnt_q <= dwell_q;
          end else begin
            sweep_done_q <= 1'b1;
            if (cont_q) begin
              sel_q <= first_sel;
              cnt_q <= dwell_q;
            end else begin
              sel_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              state_q     <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sel        = sel_q;
  assign sel_valid  = sel_valid_q;
  assign busy       = busy_q;
  assign sweep_done = sweep_done_q;
  assign err_no_ch  = err_q;

endmodule
